// File: rtl/time_pkg.sv
// Shared clock/calendar definitions: mode codes, field limits and month-length helpers.
package time_pkg;

  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    SS     = 3'd1,
    MI     = 3'd2,
    HH     = 3'd3,
    DD     = 3'd4,
    MO     = 3'd5,
    YY     = 3'd6,
    YY2    = 3'd7
  } mode_e;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [6:0] PAIR_MAX  = 7'd99;

  // Century years (year_lo == 0) are leap only when the century pair is a multiple of 4.
  function automatic logic is_leap(input logic [6:0] year_hi, input logic [6:0] year_lo);
    return ((year_lo % 7'd4) == 7'd0) &&
           ((year_lo != 7'd0) || ((year_hi % 7'd4) == 7'd0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [6:0] year_hi,
                                               input logic [6:0] year_lo);
    logic [4:0] d;
    case (month)
      4'd2:                    d = is_leap(year_hi, year_lo) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Mode/key/tick inputs and calendar field outputs of time_adjust_ctrl.
interface time_adjust_ctrl_if;
  import time_pkg::*;

  mode_e       mode;
  logic        inc_button;
  logic        tick_1hz;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [6:0]  year_hi;
  logic [6:0]  year_lo;

  modport master (
    output mode, inc_button, tick_1hz,
    input  sec, min, hour, day, month, year_hi, year_lo
  );

  modport slave (
    input  mode, inc_button, tick_1hz,
    output sec, min, hour, day, month, year_hi, year_lo
  );

endinterface

// File: rtl/btn_press_gen.sv
// Turns the active-low inc key into single-cycle step pulses; AUTO_REPEAT_EN adds
// hold-to-repeat stepping.
module btn_press_gen
`ifdef AUTO_REPEAT_EN
  import time_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
)
`endif
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc_button_i,
`ifdef AUTO_REPEAT_EN
  input  mode_e mode_i,
`endif
  output logic  step_o
);

  logic btn_q;
  logic btn_prev_q;
  logic armed_q;
  logic press;

  // armed_q blocks a key held through reset until it has been seen released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q      <= 1'b1;
      btn_prev_q <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      btn_q      <= inc_button_i;
      btn_prev_q <= btn_q;
      armed_q    <= armed_q | inc_button_i;
    end
  end

  assign press = armed_q & btn_prev_q & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] HOLD   = 32'(HOLD_CYCLES);
  localparam logic [31:0] RELOAD = 32'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  mode_e       mode_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        held;
  logic        rpt;

  // cnt_q equals cycles since the press; reloading keeps later repeats on the HOLD match.
  always_comb begin
    held  = armed_q & ~btn_q & (mode_i != NORMAL) & (mode_i == mode_q);
    rpt   = held & (cnt_q == HOLD);
    cnt_d = '0;
    if (held) cnt_d = rpt ? RELOAD : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= NORMAL;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_i;
      cnt_q  <= cnt_d;
    end
  end

  assign step_o = press | rpt;
`else
  assign step_o = press;
`endif

endmodule

// File: rtl/time_adjust_ctrl.sv
// Clock/calendar field registers: 1 Hz advance with full carry in NORMAL, per-field
// key stepping with day clamping in setting modes. Optional macro: AUTO_REPEAT_EN.
module time_adjust_ctrl
  import time_pkg::*;
#(
  parameter int unsigned YEAR_HI_INIT  = 20,
  parameter int unsigned YEAR_LO_INIT  = 24,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input logic               clk,
  input logic               rst,
  time_adjust_ctrl_if.slave bus
);

  if (REPEAT_CYCLES == 0 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_repeat_cfg
    $error("time_adjust_ctrl: REPEAT_CYCLES must be 1..HOLD_CYCLES");
  end

  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d, day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_hi_q, year_hi_d, year_lo_q, year_lo_d;
  logic [4:0] dim_cur, dim_new;
  logic       cy_min, cy_hour, cy_day, cy_mon, cy_ylo, cy_yhi;
  logic       step;

  btn_press_gen
`ifdef AUTO_REPEAT_EN
    #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
`endif
  u_btn (
    .clk          (clk),
    .rst          (rst),
    .inc_button_i (bus.inc_button),
`ifdef AUTO_REPEAT_EN
    .mode_i       (bus.mode),
`endif
    .step_o       (step)
  );

  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    month_d   = month_q;
    year_hi_d = year_hi_q;
    year_lo_d = year_lo_q;
    dim_cur   = days_in_month(month_q, year_hi_q, year_lo_q);
    dim_new   = dim_cur;
    cy_min    = sec_q >= SEC_MAX;
    cy_hour   = cy_min  && (min_q >= SEC_MAX);
    cy_day    = cy_hour && (hour_q >= HOUR_MAX);
    cy_mon    = cy_day  && (day_q >= dim_cur);
    cy_ylo    = cy_mon  && (month_q >= MONTH_MAX);
    cy_yhi    = cy_ylo  && (year_lo_q >= PAIR_MAX);
    if (bus.mode == NORMAL) begin
      if (bus.tick_1hz) begin
        sec_d = 6'(wrap_inc(7'(sec_q), 7'(SEC_MAX)));
        if (cy_min)  min_d     = 6'(wrap_inc(7'(min_q), 7'(SEC_MAX)));
        if (cy_hour) hour_d    = 5'(wrap_inc(7'(hour_q), 7'(HOUR_MAX)));
        if (cy_day)  day_d     = cy_mon ? 5'd1 : day_q + 5'd1;
        if (cy_mon)  month_d   = cy_ylo ? 4'd1 : month_q + 4'd1;
        if (cy_ylo)  year_lo_d = wrap_inc(year_lo_q, PAIR_MAX);
        if (cy_yhi)  year_hi_d = wrap_inc(year_hi_q, PAIR_MAX);
      end
    end else if (step) begin
      case (bus.mode)
        SS:      sec_d     = '0;
        MI:      min_d     = 6'(wrap_inc(7'(min_q), 7'(SEC_MAX)));
        HH:      hour_d    = 5'(wrap_inc(7'(hour_q), 7'(HOUR_MAX)));
        DD:      day_d     = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
        MO:      month_d   = (month_q >= MONTH_MAX) ? 4'd1 : month_q + 4'd1;
        YY:      year_hi_d = wrap_inc(year_hi_q, PAIR_MAX);
        YY2:     year_lo_d = wrap_inc(year_lo_q, PAIR_MAX);
        default: ;
      endcase
      // Month/year edits can shorten the month; pull day back into range in the same update.
      dim_new = days_in_month(month_d, year_hi_d, year_lo_d);
      if (day_d > dim_new) day_d = dim_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      day_q     <= 5'd1;
      month_q   <= 4'd1;
      year_hi_q <= 7'(YEAR_HI_INIT);
      year_lo_q <= 7'(YEAR_LO_INIT);
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      month_q   <= month_d;
      year_hi_q <= year_hi_d;
      year_lo_q <= year_lo_d;
    end
  end

  assign bus.sec     = sec_q;
  assign bus.min     = min_q;
  assign bus.hour    = hour_q;
  assign bus.day     = day_q;
  assign bus.month   = month_q;
  assign bus.year_hi = year_hi_q;
  assign bus.year_lo = year_lo_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Scoreboard bench for time_adjust_ctrl: directed stimulus queues expected calendar
// snapshots, a negedge monitor pops and compares them against the DUT fields.
module tb_time_adjust_ctrl;
  import time_pkg::*;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD30_HOUR = 6;
`else
  localparam int HOLD30_HOUR = 1;
`endif

  typedef struct {
    string      name;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] yh;
    logic [6:0] yl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_req = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  time_adjust_ctrl_if bus();

  time_adjust_ctrl #(
    .YEAR_HI_INIT  (20),
    .YEAR_LO_INIT  (24),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_req) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: check requested with empty expectation queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.sec !== e.sec || bus.min !== e.min || bus.hour !== e.hour ||
            bus.day !== e.day || bus.month !== e.month ||
            bus.year_hi !== e.yh || bus.year_lo !== e.yl) begin
          n_bad++;
          $display("FAIL %s: got %0d:%0d:%0d %0d-%0d %0d/%0d want %0d:%0d:%0d %0d-%0d %0d/%0d",
                   e.name, bus.hour, bus.min, bus.sec, bus.day, bus.month, bus.year_hi,
                   bus.year_lo, e.hour, e.min, e.sec, e.day, e.month, e.yh, e.yl);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int h, input int mi, input int s,
                       input int d, input int mo, input int yh, input int yl);
    exp_t e;
    e.name = name;
    e.sec = 6'(s); e.min = 6'(mi); e.hour = 5'(h);
    e.day = 5'(d); e.month = 4'(mo); e.yh = 7'(yh); e.yl = 7'(yl);
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    #4;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      bus.inc_button = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.inc_button = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1;
      @(posedge clk); #1;
      bus.tick_1hz = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // From the reset state (00:00:00 01-01 20/24); day is set last so no clamp interferes.
  task automatic preset(input int h, input int mi, input int s, input int d,
                        input int mo, input int yh, input int yl);
    do_reset();
    bus.mode = HH;  press(h);
    bus.mode = MI;  press(mi);
    bus.mode = MO;  press(mo - 1);
    bus.mode = YY;  press((yh + 80) % 100);
    bus.mode = YY2; press((yl + 76) % 100);
    bus.mode = DD;  press(d - 1);
    bus.mode = NORMAL;
    ticks(s);
  endtask

  initial begin
    bus.mode       = NORMAL;
    bus.inc_button = 1'b1;
    bus.tick_1hz   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    check("reset", 0, 0, 0, 1, 1, 20, 24);
    ticks(59);
    check("tick59", 0, 0, 59, 1, 1, 20, 24);
    ticks(1);
    check("tick60", 0, 1, 0, 1, 1, 20, 24);

    bus.mode = MI;
    press(58);
    check("mi_to_59", 0, 59, 0, 1, 1, 20, 24);
    press(1);
    check("mi_wrap_no_carry", 0, 0, 0, 1, 1, 20, 24);

    bus.mode = NORMAL;
    ticks(37);
    press(1);
    check("normal_press_ignored", 0, 0, 37, 1, 1, 20, 24);
    bus.mode = SS;
    ticks(5);
    check("ss_freeze", 0, 0, 37, 1, 1, 20, 24);
    press(1);
    check("ss_clear", 0, 0, 0, 1, 1, 20, 24);

    preset(23, 59, 59, 31, 12, 20, 99);
    check("preset_eoy", 23, 59, 59, 31, 12, 20, 99);
    ticks(1);
    check("carry_all", 0, 0, 0, 1, 1, 21, 0);

    preset(23, 59, 59, 28, 2, 20, 24); ticks(1);
    check("leap_2024", 0, 0, 0, 29, 2, 20, 24);
    preset(23, 59, 59, 28, 2, 20, 23); ticks(1);
    check("leap_2023", 0, 0, 0, 1, 3, 20, 23);
    preset(23, 59, 59, 28, 2, 21, 0); ticks(1);
    check("leap_2100", 0, 0, 0, 1, 3, 21, 0);
    preset(23, 59, 59, 28, 2, 20, 0); ticks(1);
    check("leap_2000", 0, 0, 0, 29, 2, 20, 0);

    preset(0, 0, 0, 31, 1, 20, 23);
    bus.mode = MO; press(1);
    check("clamp_mo", 0, 0, 0, 28, 2, 20, 23);
    preset(0, 0, 0, 29, 2, 20, 24);
    bus.mode = YY2; press(1);
    check("clamp_yy2", 0, 0, 0, 28, 2, 20, 25);
    preset(0, 0, 0, 1, 1, 99, 24);
    check("yy_at_99", 0, 0, 0, 1, 1, 99, 24);
    bus.mode = YY; press(1);
    check("yy_wrap", 0, 0, 0, 1, 1, 0, 24);

    bus.mode = HH;
    bus.inc_button = 1'b0;
    do_reset();
    repeat (4) @(posedge clk);
    #1 bus.inc_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("held_through_reset", 0, 0, 0, 1, 1, 20, 24);
    press(1);
    check("press_after_release", 1, 0, 0, 1, 1, 20, 24);

    do_reset();
    bus.mode = HH;
    bus.inc_button = 1'b0;
    repeat (30) @(posedge clk);
    #1 bus.inc_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_30", HOLD30_HOUR, 0, 0, 1, 1, 20, 24);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
